// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg_pkg;

    // Segment order is {dp,g,f,e,d,c,b,a}, active-high.
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;

    // Standard hex glyphs 0..F; dp (bit 7) is never lit.
    localparam logic [7:0] SEG_HEX_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F,
        8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C,
        8'h39, 8'h5E, 8'h79, 8'h71
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to seven-segment glyph lookup.
// Latency: combinational.
// Backpressure: none.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    // Direct table lookup; the table keeps dp clear for every glyph.
    assign seg = SEG_HEX_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with frame-synchronous shadow load and blink.
// Latency: outputs registered; a captured load is visible on digit 0 of the following frame.
// Backpressure: none; load is a sticky request serviced at the next frame boundary.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [4*NUM_DIGITS-1:0] digit_val,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dash_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    load,
    output logic [7:0]              seg_data,
    output logic [NUM_DIGITS-1:0]   seg_select,
    output logic                    frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(PRESCALE);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_nxt;
    logic [FW-1:0]           fcnt;
    logic                    phase;
    logic                    phase_nxt;
    logic                    pending;
    logic                    tick;
    logic                    boundary;
    logic                    capture;

    logic [4*NUM_DIGITS-1:0] sh_val;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic [NUM_DIGITS-1:0]   sh_dash;
    logic [NUM_DIGITS-1:0]   sh_blink;

    logic [4*NUM_DIGITS-1:0] src_val;
    logic [NUM_DIGITS-1:0]   src_en;
    logic [NUM_DIGITS-1:0]   src_dash;
    logic [NUM_DIGITS-1:0]   src_blink;

    logic [3:0]              nibble;
    logic [7:0]              hex_seg;
    logic [7:0]              data_nxt;
    logic [NUM_DIGITS-1:0]   sel_nxt;

    assign tick     = (presc == PW'(PRESCALE - 1));
    assign boundary = tick && (idx == IW'(NUM_DIGITS - 1));
    assign capture  = boundary && (pending || load);
    assign idx_nxt  = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

    // On a capturing boundary, digit 0 of the new frame must already see the
    // fresh inputs, so bypass the shadows for that one decode.
    assign src_val   = capture ? digit_val  : sh_val;
    assign src_en    = capture ? digit_en   : sh_en;
    assign src_dash  = capture ? dash_mask  : sh_dash;
    assign src_blink = capture ? blink_mask : sh_blink;

    // Same idea for blink: the phase that takes effect at this boundary
    // governs the whole new frame, starting with digit 0.
    assign phase_nxt = (boundary && (fcnt == FW'(BLINK_FRAMES - 1))) ? ~phase : phase;

    assign nibble  = src_val[4*idx_nxt +: 4];
    assign sel_nxt = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nxt;

    seg_hex_decode u_hex (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    // Priority: blank beats dash beats blink-off beats the hex glyph.
    always_comb begin
        data_nxt = hex_seg;
        if (!src_en[idx_nxt]) begin
            data_nxt = SEG_BLANK;
        end else if (src_dash[idx_nxt]) begin
            data_nxt = SEG_DASH;
        end else if (src_blink[idx_nxt] && phase_nxt) begin
            data_nxt = SEG_BLANK;
        end
    end

    // Slot prescaler: free-running 0..PRESCALE-1.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Digit scan: advance index and register strobe/pattern together on each tick.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx        <= '0;
            seg_select <= {{(NUM_DIGITS-1){1'b0}}, 1'b1};
            seg_data   <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (tick) begin
                idx        <= idx_nxt;
                seg_select <= sel_nxt;
                seg_data   <= data_nxt;
            end
        end
    end

    // Load handling: remember the request, capture inputs only at a frame boundary.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending  <= 1'b0;
            sh_val   <= '0;
            sh_en    <= '0;
            sh_dash  <= '0;
            sh_blink <= '0;
        end else if (capture) begin
            pending  <= 1'b0;
            sh_val   <= digit_val;
            sh_en    <= digit_en;
            sh_dash  <= dash_mask;
            sh_blink <= blink_mask;
        end else if (load) begin
            pending  <= 1'b1;
        end
    end

    // Blink timing: count frame boundaries and flip the phase every BLINK_FRAMES of them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (boundary) begin
            phase <= phase_nxt;
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (3 digits, 4-cycle slots, 2-frame blink).
// Reference model works from edge count since reset: slot = k/P, digit = slot%N.
// Inputs are driven on the falling edge, outputs compared on the falling edge.
module tb_seg_scan_driver;

    localparam int N  = 3;
    localparam int P  = 4;
    localparam int BF = 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [11:0]   digit_val = '0;
    logic [2:0]    digit_en = '0;
    logic [2:0]    dash_mask = '0;
    logic [2:0]    blink_mask = '0;
    logic          load = 1'b0;
    logic [7:0]    seg_data;
    logic [2:0]    seg_select;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    seg_scan_driver #(
        .NUM_DIGITS   (N),
        .PRESCALE     (P),
        .BLINK_FRAMES (BF)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .digit_val  (digit_val),
        .digit_en   (digit_en),
        .dash_mask  (dash_mask),
        .blink_mask (blink_mask),
        .load       (load),
        .seg_data   (seg_data),
        .seg_select (seg_select),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_pat(input logic [3:0] n);
        case (n)
            4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
            4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
            4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
            4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
        endcase
    endfunction

    // Reference model state
    int          k;
    logic [11:0] m_val;
    logic [2:0]  m_en, m_dash, m_blink;
    bit          m_pend;
    logic [7:0]  e_dat;
    logic [2:0]  e_sel;
    logic        e_fd;

    function automatic logic [7:0] content(input int d, input bit ph);
        if (!m_en[d])              return 8'h00;
        if (m_dash[d])             return 8'h40;
        if (m_blink[d] && ph)      return 8'h00;
        return hex_pat(m_val[4*d +: 4]);
    endfunction

    task automatic model_reset();
        k = 0; m_val = '0; m_en = '0; m_dash = '0; m_blink = '0; m_pend = 0;
        e_sel = 3'b001; e_dat = 8'h00; e_fd = 1'b0;
    endtask

    task automatic model_step();
        int s, d;
        bit ph;
        if (!RST_N) begin
            model_reset();
            return;
        end
        k++;
        e_fd = 1'b0;
        if (k % P == 0) begin
            s = k / P;
            d = s % N;
            if (d == 0) e_fd = 1'b1;
            if (d == 0 && (m_pend || load)) begin
                m_val = digit_val; m_en = digit_en; m_dash = dash_mask; m_blink = blink_mask;
                m_pend = 0;
            end else if (load) begin
                m_pend = 1;
            end
            ph = bit'(((s / N) / BF) % 2);
            e_sel = 3'(1 << d);
            e_dat = content(d, ph);
        end else if (load) begin
            m_pend = 1;
        end
    endtask

    // One clock: model follows the rising edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        chk("seg_select", 32'(seg_select), 32'(e_sel));
        chk("seg_data", 32'(seg_data), 32'(e_dat));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic pulse_load();
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    // Wait for the next frame start and compare the three digit glyphs to constants.
    task automatic expect_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            if (frame_done) seen = 1;
        end
        chk("frame_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("frame_d0", 32'(seg_data), 32'(d0));
            repeat (P) cyc();
            chk("frame_d1", 32'(seg_data), 32'(d1));
            repeat (P) cyc();
            chk("frame_d2", 32'(seg_data), 32'(d2));
        end
    endtask

    initial begin
        bit found;
        model_reset();
        repeat (2) cyc();
        RST_N = 1'b1;

        // Idle scan with empty shadows
        repeat (12) cyc();

        // Basic capture and decode
        digit_val = 12'h7A1; digit_en = 3'b111;
        cyc(); cyc();
        pulse_load();
        expect_frame(8'h06, 8'h77, 8'h07);

        // Dash, then enable overriding dash
        dash_mask = 3'b010;
        pulse_load();
        expect_frame(8'h06, 8'h40, 8'h07);
        digit_en = 3'b101;
        pulse_load();
        expect_frame(8'h06, 8'h00, 8'h07);

        // Blink on digit 0 over several frames
        digit_en = 3'b111; dash_mask = 3'b000; blink_mask = 3'b001; digit_val = 12'h7A8;
        pulse_load();
        repeat (12 * 6) cyc();

        // Load in the boundary cycle itself
        blink_mask = 3'b000; digit_val = 12'h123;
        for (int i = 0; i < 12 && ((k + 1) % (P * N) != 0); i++) cyc();
        pulse_load();
        chk("bnd_load_fd", 32'(frame_done), 32'd1);
        chk("bnd_load_d0", 32'(seg_data), 32'h4F);

        // Several loads in one frame; value at the boundary wins
        digit_val = 12'h456; pulse_load();
        cyc();
        digit_val = 12'h789; pulse_load();
        digit_val = 12'hABC; pulse_load();
        digit_val = 12'h0E5;
        expect_frame(8'h6D, 8'h79, 8'h3F);

        // Asynchronous reset while digit 2 is showing
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (seg_select == 3'b100) found = 1;
        end
        chk("found_digit2", 32'(found), 32'd1);
        cyc();
        RST_N = 1'b0;
        #1;
        chk("rst_sel", 32'(seg_select), 32'b001);
        chk("rst_dat", 32'(seg_data), 32'h00);
        chk("rst_fd", 32'(frame_done), 32'd0);
        repeat (3) cyc();
        RST_N = 1'b1;
        repeat (3) cyc();
        chk("rel_sel_d0", 32'(seg_select), 32'b001);
        cyc();
        chk("rel_sel_d1", 32'(seg_select), 32'b010);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            digit_val  = 12'($urandom);
            digit_en   = 3'($urandom);
            dash_mask  = 3'($urandom);
            blink_mask = 3'($urandom);
            load       = ($urandom_range(0, 7) == 0);
            cyc();
        end
        load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
